// File: rtl/ram_16x8_pkg.sv
// Shared types and constants for the 16x8 program/data RAM and its loader.
package ram_16x8_pkg;

  // Default geometry: 4-bit MAR address, 8-bit W bus.
  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 8;
  localparam int MEM_DEPTH = 2 ** AW_DEF;

  // Loader FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/ram_16x8_if.sv
// Bus bundle between the CPU side (MAR, W bus, program loader) and the RAM.
interface ram_16x8_if #(
  parameter int AW = ram_16x8_pkg::AW_DEF,
  parameter int DW = ram_16x8_pkg::DW_DEF
) ();

  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          nCE;
  logic          nWE;
  logic          prog;
  logic [DW-1:0] ld_data;
  logic          ld_valid;
  logic          ld_ready;
  logic          ld_done;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] WBUS;
  logic          WBUS_oe;

  // CPU / loader side: drives address, data, strobes and the byte stream.
  modport master (
    output address, data, nCE, nWE, prog, ld_data, ld_valid,
    input  ld_ready, ld_done, ld_addr, WBUS, WBUS_oe
  );

  // RAM side.
  modport slave (
    input  address, data, nCE, nWE, prog, ld_data, ld_valid,
    output ld_ready, ld_done, ld_addr, WBUS, WBUS_oe
  );

endinterface

// File: rtl/ram_16x8_loader_fsm.sv
// Program-loader FSM: fills memory sequentially from a valid/ready byte stream.
module ram_loader_fsm
  import ram_16x8_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  output logic          ld_done,
  output logic [AW-1:0] ld_addr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);

  ld_state_t state;

  // A load starts only on a rising edge of prog. prog_q resets to 1 so that
  // holding prog high through a reset does not silently restart a load; the
  // operator has to drop prog and raise it again.
  logic prog_q;

  // A byte is taken when the handshake completes while still in load mode.
  // Dropping prog in the same cycle aborts the load instead of writing, so the
  // loader never competes with a run-mode write for the storage port.
  logic xfer;
  assign xfer = ld_ready && ld_valid && prog;

  // State register plus registered ld_ready/ld_done/ld_addr outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ld_addr  <= '0;
      ld_done  <= 1'b0;
      ld_ready <= 1'b0;
      prog_q   <= 1'b1;
    end else begin
      prog_q <= prog;
      unique case (state)
        IDLE: begin
          if (prog && !prog_q) begin
            state    <= LOAD;
            ld_addr  <= '0;
            ld_done  <= 1'b0;
            ld_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (!prog) begin
            state    <= IDLE;
            ld_ready <= 1'b0;
          end else if (xfer) begin
            ld_addr <= ld_addr + AW'(1);
            if (ld_addr == '1) begin
              state    <= DONE;
              ld_done  <= 1'b1;
              ld_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          if (!prog) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en   = xfer;
  assign wr_addr = ld_addr;
  assign wr_data = ld_data;

endmodule

// File: rtl/ram_16x8.sv
// 16x8 program/data RAM behind the MAR, with a built-in program loader.
// Reads are combinational onto the W bus; writes happen on the rising edge,
// either from the W bus in run mode or from the loader in program mode.
module ram_16x8
  import ram_16x8_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic       CLK,
  input logic       CLR,
  ram_16x8_if.slave bus
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  logic          ld_wr_en;
  logic [AW-1:0] ld_wr_addr;
  logic [DW-1:0] ld_wr_data;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic          rd_en;

  ram_loader_fsm #(
    .AW(AW),
    .DW(DW)
  ) u_loader (
    .clk      (CLK),
    .rst      (CLR),
    .prog     (bus.prog),
    .ld_data  (bus.ld_data),
    .ld_valid (bus.ld_valid),
    .ld_ready (bus.ld_ready),
    .ld_done  (bus.ld_done),
    .ld_addr  (bus.ld_addr),
    .wr_en    (ld_wr_en),
    .wr_addr  (ld_wr_addr),
    .wr_data  (ld_wr_data)
  );

  // Write-port mux: the loader owns the port while prog is high, so the bus
  // strobes cannot corrupt memory during a load.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.address;
    mem_wdata = bus.data;
    if (bus.prog) begin
      mem_we    = ld_wr_en;
      mem_waddr = ld_wr_addr;
      mem_wdata = ld_wr_data;
    end else begin
      mem_we = !bus.nWE;
    end
  end

  // Storage array: cleared by reset, single write port.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Zero-latency read onto the W bus; reading the array before the edge means
  // a read-during-write shows the old contents.
  always_comb begin
    rd_en       = !CLR && !bus.prog && !bus.nCE;
    bus.WBUS    = rd_en ? mem[bus.address] : '0;
    bus.WBUS_oe = rd_en;
  end

endmodule

// File: tb/tb_ram_16x8.sv
// Self-checking bench for ram_16x8: vector table for readback, a reference
// memory model feeding an expected-value queue, and hand-written sequences
// for loader backpressure, mode isolation and reset mid-load.
module tb_ram_16x8;
  import ram_16x8_pkg::*;

  logic CLK = 1'b0;
  logic CLR;

  int errors = 0;
  int checks = 0;

  logic [7:0] model [16];
  int         ldIdx;
  int         readyCount;
  logic [7:0] expQ [$];

  typedef struct {
    logic [3:0] addr;
    logic [7:0] expData;
  } readVec_t;

  readVec_t vecs [16];

  ram_16x8_if bus ();

  ram_16x8 dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  // Free-running 100 MHz clock.
  always #5 CLK = ~CLK;

  // Hard time limit so the bench never hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic nce,
                               input logic nwe, input logic [7:0] d);
    bus.address = addr;
    bus.nCE     = nce;
    bus.nWE     = nwe;
    bus.data    = d;
  endtask

  // Reads every listed address in run mode and compares against the queue.
  task automatic readRange(input int lo, input int hi, input string tag);
    for (int a = lo; a <= hi; a++) begin
      expQ.push_back(model[a]);
    end
    for (int a = lo; a <= hi; a++) begin
      logic [7:0] e;
      applyStimulus(4'(a), 1'b0, 1'b1, 8'h00);
      #1;
      e = expQ.pop_front();
      checkOutput($sformatf("%s_rd%0d", tag, a), 32'(bus.WBUS), 32'(e));
      checkOutput($sformatf("%s_oe%0d", tag, a), 32'(bus.WBUS_oe), 32'd1);
    end
  endtask

  // Enters LOAD by taking prog low for one edge then high.
  task automatic startLoad();
    bus.ld_valid = 1'b0;
    bus.nWE      = 1'b1;
    bus.prog     = 1'b0;
    tick();
    bus.prog = 1'b1;
    tick();
    ldIdx = 0;
    checkOutput("start_ready", 32'(bus.ld_ready), 32'd1);
    checkOutput("start_done", 32'(bus.ld_done), 32'd0);
    checkOutput("start_addr", 32'(bus.ld_addr), 32'd0);
  endtask

  // Streams n bytes base, base+1, ... and mirrors accepted bytes in the model.
  task automatic streamBytes(input int n, input logic [7:0] base);
    int sent  = 0;
    int guard = 0;
    bus.ld_valid = 1'b1;
    while (sent < n && guard < 64) begin
      bus.ld_data = base + 8'(sent);
      @(negedge CLK);
      if (bus.ld_ready) begin
        model[ldIdx] = bus.ld_data;
        ldIdx        = (ldIdx + 1) % 16;
        sent++;
        readyCount++;
      end
      tick();
      guard++;
    end
    bus.ld_valid = 1'b0;
    if (sent < n) checkOutput("stream_timeout", 32'(sent), 32'(n));
  endtask

  initial begin
    int cnt;

    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{addr: 4'(i), expData: 8'(8'h10 + i)};
      model[i] = 8'h00;
    end
    ldIdx      = 0;
    readyCount = 0;

    // Reset state with a read requested.
    CLR = 1'b1;
    bus.prog = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data = 8'h00;
    applyStimulus(4'd5, 1'b0, 1'b1, 8'h00);
    #3;
    checkOutput("rst_wbus", 32'(bus.WBUS), 32'h00);
    checkOutput("rst_oe", 32'(bus.WBUS_oe), 32'd0);
    checkOutput("rst_ready", 32'(bus.ld_ready), 32'd0);
    checkOutput("rst_done", 32'(bus.ld_done), 32'd0);
    checkOutput("rst_ldaddr", 32'(bus.ld_addr), 32'd0);
    tick();
    tick();
    CLR = 1'b0;
    tick();
    readRange(0, 15, "rst");

    // Full load of 8'h10..8'h1F with valid held high.
    $display("[TB] full load");
    startLoad();
    readyCount = 0;
    streamBytes(16, 8'h10);
    checkOutput("full_ready_cycles", 32'(readyCount), 32'd16);
    checkOutput("full_done", 32'(bus.ld_done), 32'd1);
    checkOutput("full_addr", 32'(bus.ld_addr), 32'd0);
    // Extra 8'hFF bytes in DONE must be refused and ignored.
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hFF;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (bus.ld_ready) cnt++;
      tick();
    end
    bus.ld_valid = 1'b0;
    checkOutput("done_ready_cycles", 32'(cnt), 32'd0);
    checkOutput("done_held", 32'(bus.ld_done), 32'd1);
    bus.prog = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].addr, 1'b0, 1'b1, 8'h00);
      #1;
      checkOutput($sformatf("vec_rd%0d", i), 32'(bus.WBUS), 32'(vecs[i].expData));
      checkOutput($sformatf("vec_oe%0d", i), 32'(bus.WBUS_oe), 32'd1);
    end

    // Reload with a 3-cycle gap mid-stream.
    $display("[TB] backpressure");
    startLoad();
    streamBytes(5, 8'h30);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checkOutput($sformatf("gap_addr%0d", c), 32'(bus.ld_addr), 32'd5);
      checkOutput($sformatf("gap_ready%0d", c), 32'(bus.ld_ready), 32'd1);
      tick();
    end
    streamBytes(11, 8'h35);
    checkOutput("gap_done", 32'(bus.ld_done), 32'd1);
    checkOutput("gap_final_addr", 32'(bus.ld_addr), 32'd0);
    bus.prog = 1'b0;
    tick();
    readRange(0, 15, "gap");

    // Run-mode read-during-write then read back.
    $display("[TB] run-mode write");
    tick();
    applyStimulus(4'hA, 1'b0, 1'b0, 8'h5C);
    #1;
    checkOutput("rdw_old", 32'(bus.WBUS), 32'h3A);
    tick();
    bus.nWE = 1'b1;
    #1;
    checkOutput("rdw_new", 32'(bus.WBUS), 32'h5C);
    model[10] = 8'h5C;
    bus.nCE = 1'b1;
    #1;
    checkOutput("nce_wbus", 32'(bus.WBUS), 32'h00);
    checkOutput("nce_oe", 32'(bus.WBUS_oe), 32'd0);

    // Bus strobes are ignored while prog is high.
    $display("[TB] mode isolation");
    bus.prog = 1'b1;
    applyStimulus(4'd2, 1'b0, 1'b0, 8'hAA);
    #1;
    checkOutput("iso_wbus", 32'(bus.WBUS), 32'h00);
    checkOutput("iso_oe", 32'(bus.WBUS_oe), 32'd0);
    tick();
    tick();
    checkOutput("iso_oe_load", 32'(bus.WBUS_oe), 32'd0);
    checkOutput("iso_ldaddr", 32'(bus.ld_addr), 32'd0);
    bus.nWE = 1'b1;
    bus.nCE = 1'b1;
    bus.prog = 1'b0;
    tick();
    readRange(2, 2, "iso");

    // Reset after 7 bytes, then check the load only restarts on a prog edge.
    $display("[TB] reset mid-load");
    startLoad();
    streamBytes(7, 8'h50);
    checkOutput("mid_addr", 32'(bus.ld_addr), 32'd7);
    #2;
    CLR = 1'b1;
    #1;
    checkOutput("mid_rst_addr", 32'(bus.ld_addr), 32'd0);
    checkOutput("mid_rst_done", 32'(bus.ld_done), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.ld_ready), 32'd0);
    tick();
    CLR = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    ldIdx = 0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h99;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (bus.ld_ready) cnt++;
      tick();
    end
    bus.ld_valid = 1'b0;
    checkOutput("held_prog_ready", 32'(cnt), 32'd0);
    checkOutput("held_prog_addr", 32'(bus.ld_addr), 32'd0);
    bus.prog = 1'b0;
    tick();
    readRange(0, 7, "clr");
    bus.nCE  = 1'b1;
    bus.prog = 1'b1;
    tick();
    checkOutput("restart_ready", 32'(bus.ld_ready), 32'd1);
    checkOutput("restart_addr", 32'(bus.ld_addr), 32'd0);
    streamBytes(3, 8'h70);
    checkOutput("restart_addr3", 32'(bus.ld_addr), 32'd3);
    bus.prog = 1'b0;
    tick();
    readRange(0, 3, "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_16x8.md
Name: ram_16x8

Overview:
- Program/data RAM responder that sits on the far side of the memory address register.
- It takes the 4-bit address held in the MAR and either drives the addressed byte onto the W bus or stores a byte from it.
- It also contains a program-loader FSM. The loader fills memory sequentially from an external byte stream using a valid/ready handshake, so a program can be loaded before the CPU runs.

Parameters:
- AW, 4, address width (memory depth = 2**AW = 16)
- DW, 8, data width

Ports:
- CLK  input  1  clock; all state changes on the rising edge
- CLR  input  1  reset; asynchronous, active-high
- address  input  AW  read/write address from the MAR
- data  input  DW  write data from the W bus (run-mode writes)
- nCE  input  1  chip enable, active-low; 0 = drive the addressed byte onto the W bus
- nWE  input  1  write enable, active-low; 0 = write `data` to mem[address] at the clock edge
- prog  input  1  1 = program-load mode; 0 = run mode
- ld_data  input  DW  loader byte stream
- ld_valid  input  1  loader byte valid
- ld_ready  output  1  RAM accepts a loader byte this cycle
- ld_done  output  1  all 16 locations loaded since load start
- ld_addr  output  AW  next loader write address
- WBUS  output  DW  read data to the W bus
- WBUS_oe  output  1  1 = WBUS carries valid data; bus mux uses this

Behaviour:
- Reset (CLR=1, asynchronous): all 16 memory words = 0; FSM = IDLE; ld_addr = 0; ld_done = 0; ld_ready = 0.
- Outputs during reset: WBUS = 0, WBUS_oe = 0.
- Run-mode read (prog=0, nCE=0):
  - WBUS = mem[address], combinational, zero latency, so the IR or B register can capture it at the same edge.
  - WBUS_oe = 1.
  - Otherwise WBUS = 0 and WBUS_oe = 0.
- Run-mode write (prog=0, nWE=0): mem[address] <= data at the rising edge.
  - Read-during-write with nCE=0 and nWE=0 in the same cycle: WBUS shows the old contents; the new value is visible from the next cycle.
- Loader FSM states: IDLE, LOAD, DONE.
  - IDLE: ld_ready = 0. When prog=1, go to LOAD and set ld_addr = 0, ld_done = 0.
  - LOAD: ld_ready = 1. A byte transfers when ld_valid & ld_ready; on that edge mem[ld_addr] <= ld_data and ld_addr increments.
  - LOAD with ld_addr = 15 and a transfer: ld_addr wraps to 0, ld_done = 1, go to DONE.
  - No transfer in a cycle: ld_addr holds.
  - DONE: ld_ready = 0; ld_done stays 1. Extra ld_valid pulses are ignored and memory is not modified.
  - prog falling to 0 in LOAD or DONE: return to IDLE.
    - ld_done keeps its value until the next load start.
    - A partial load leaves the written locations intact.
  - prog rising again from IDLE restarts the load at address 0.
- Mode interaction while prog=1:
  - nCE and nWE are ignored; WBUS = 0, WBUS_oe = 0.
  - The run-mode write path is disabled, so the bus cannot corrupt memory during loading.
- Reset mid-load: immediate return to IDLE with memory cleared. The load must be restarted by toggling prog (0 then 1).
- All address arithmetic is modulo 2**AW; there are no out-of-range addresses.

Decomposition:
- Shared package holds:
  - loader state typedef/localparams: IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2
  - AW and DW defaults
  - the MEM_DEPTH constant
- One natural sub-module, ram_loader_fsm. It owns the state register, ld_addr, ld_done and ld_ready, and outputs a write strobe plus address/data.
- ram_16x8 holds the storage array, the write-port mux (loader vs. run-mode) and the read/oe logic.

Test Plan:
1. Reset: assert CLR with prog=0, nCE=0, address=5 -> WBUS=8'h00, WBUS_oe=0. Deassert, then read all 16 addresses -> every word 8'h00.
2. Full load: prog=1, stream bytes 8'h10..8'h1F with ld_valid held high ->
   - ld_ready=1 for exactly 16 cycles;
   - ld_done=1 after the 16th transfer, ld_addr=0;
   - prog=0 then a read of address 3 -> WBUS=8'h13, WBUS_oe=1.
3. Backpressure and gaps: in LOAD, drop ld_valid for 3 cycles mid-stream -> ld_addr holds. In DONE, pulse ld_valid with 8'hFF -> no location changes, ld_ready stays 0.
4. Run-mode write/read:
   - address=4'hA, data=8'h5C, nWE=0, nCE=0 in the same cycle -> WBUS shows the old value.
   - Next cycle, nWE=1 -> WBUS=8'h5C.
   - nCE=1 -> WBUS=0, WBUS_oe=0.
5. Mode isolation: prog=1, drive nWE=0, nCE=0, address=2 with data=8'hAA -> mem[2] unchanged, WBUS_oe=0.
6. Reset mid-load: after 7 bytes, assert CLR for one cycle ->
   - FSM returns to IDLE, ld_addr=0, ld_done=0, memory cleared;
   - holding prog=1 does not restart the load; toggling prog 0->1 does, and the load proceeds from address 0.
